// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Display stage for the game top level. Two 8-bit binary values (score on
// val_a, seconds remaining on val_b) are converted to BCD once per scan frame
// by a sequential shift-add-3 engine. The result is time-multiplexed onto an
// 8-digit common-anode display.
//
// Digit map (index -> content):
//   0/1/2 : val_b ones/tens/hundreds
//   3/4   : unused, all anodes off
//   5/6/7 : val_a ones/tens/hundreds
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   val_a  in   [7:0] score, 0..255
//   val_b  in   [7:0] time remaining, 0..255
//   blank  in   1 = all anodes off, scan and conversion keep running
//   an     out  [7:0] anode enables, active-low, an[i] = digit i
//   a2g    out  [6:0] segments, active-low, bit6 = a .. bit0 = g
//   busy   out  1 while a BCD conversion is in progress
//
// Parameter:
//   SCAN_DIV  clk cycles per digit slot (frame = 8*SCAN_DIV cycles)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, a zero hundreds digit is blanked and
//                          a zero tens digit is blanked if hundreds is also
//                          zero. The anode is still driven for those slots.
//
// Handshake: none. Inputs are sampled only on the edge where the digit index
// wraps 7->0; the display registers update 9 cycles later, all six digits at
// once. busy is high for the 8 iteration cycles in between.
// -----------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_a,
  input  logic [7:0] val_b,
  input  logic       blank,
  output logic [7:0] an,
  output logic [6:0] a2g,
  output logic       busy
);

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif

  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_LOAD = 2'd2
  } conv_state_e;

  // Scan timing
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          slot_end;
  logic          wrap;

  // Conversion engine: {hundreds, tens, ones, binary} per value
  conv_state_e   state_q;
  logic [2:0]    cnt_q;
  logic          busy_q;
  logic [19:0]   sha_q, sha_d;
  logic [19:0]   shb_q, shb_d;

  // Display registers: {hundreds, tens, ones}
  logic [11:0]   disp_a_q;
  logic [11:0]   disp_b_q;

  // Registered outputs
  logic [7:0]    an_q, an_d;
  logic [6:0]    a2g_q, a2g_d;

  // One double-dabble iteration: add 3 to any BCD nibble >= 5, then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int k = 0; k < 3; k++) begin
      if (t[8+4*k +: 4] >= 4'd5) t[8+4*k +: 4] = t[8+4*k +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_end = (presc_q == PRESC_MAX);
    presc_d  = slot_end ? '0 : presc_q + 1'b1;
    idx_d    = slot_end ? idx_q + 3'd1 : idx_q;
    // Capture edge: last cycle of slot 7, index about to wrap to 0.
    wrap     = slot_end && (idx_q == 3'd7);
    sha_d    = dd_step(sha_q);
    shb_d    = dd_step(shb_q);
  end

  // Conversion FSM. A wrap always restarts the engine; with a frame of at
  // least 8*16 cycles a conversion always finishes long before the next wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      sha_q    <= 20'd0;
      shb_q    <= 20'd0;
      disp_a_q <= 12'd0;
      disp_b_q <= 12'd0;
    end else if (wrap) begin
      state_q <= S_CONV;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b1;
      sha_q   <= {12'd0, val_a};
      shb_q   <= {12'd0, val_b};
    end else begin
      case (state_q)
        S_CONV: begin
          sha_q <= sha_d;
          shb_q <= shb_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          // Shadow -> display in one edge so no partial value is ever shown.
          disp_a_q <= sha_q[19:8];
          disp_b_q <= shb_q[19:8];
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Digit selection for the current index.
  logic [3:0] dig;
  logic       hide;
  logic       slot_used;

  always_comb begin
    dig       = 4'd0;
    hide      = 1'b0;
    slot_used = 1'b1;
    case (idx_q)
      3'd0: dig = disp_b_q[3:0];
      3'd1: begin
        dig  = disp_b_q[7:4];
        hide = LZB_EN && (disp_b_q[11:8] == 4'd0) && (disp_b_q[7:4] == 4'd0);
      end
      3'd2: begin
        dig  = disp_b_q[11:8];
        hide = LZB_EN && (disp_b_q[11:8] == 4'd0);
      end
      3'd5: dig = disp_a_q[3:0];
      3'd6: begin
        dig  = disp_a_q[7:4];
        hide = LZB_EN && (disp_a_q[11:8] == 4'd0) && (disp_a_q[7:4] == 4'd0);
      end
      3'd7: begin
        dig  = disp_a_q[11:8];
        hide = LZB_EN && (disp_a_q[11:8] == 4'd0);
      end
      default: slot_used = 1'b0;
    endcase

    if (blank || !slot_used) begin
      an_d  = 8'hFF;
      a2g_d = 7'h7F;
    end else begin
      an_d  = ~(8'b1 << idx_q);
      a2g_d = hide ? 7'h7F : seg_code(dig);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFF;
      a2g_q   <= 7'h7F;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      a2g_q   <= a2g_d;
    end
  end

  assign an   = an_q;
  assign a2g  = a2g_q;
  assign busy = busy_q;

endmodule
